// File: rtl/rv_pkg.sv
// Shared RV32I encoding definitions: instruction formats, check result codes,
// opcode constants and the immediate legality check used by the encoder.
package rv_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_RANGE = 2'd1;
   localparam logic [1:0] ERR_ALIGN = 2'd2;
   localparam logic [1:0] ERR_FMT   = 2'd3;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_WORD = {12'd0, 5'd0, 3'd0, 5'd0, OP_IMM};

   function automatic logic imm_in_range(input logic [31:0] imm,
                                         input logic signed [31:0] lo,
                                         input logic signed [31:0] hi);
      return ($signed(imm) >= lo) && ($signed(imm) <= hi);
   endfunction

   // Range is reported ahead of alignment, so an odd out-of-range offset is a range error.
   function automatic logic [1:0] check_imm(input logic [2:0] fmt, input logic [31:0] imm);
      logic [1:0] code;
      code = ERR_NONE;
      case (fmt)
         FMT_R: code = ERR_NONE;
         FMT_I, FMT_S: begin
            if (!imm_in_range(imm, -32'sd2048, 32'sd2047)) code = ERR_RANGE;
            else                                           code = ERR_NONE;
         end
         FMT_B: begin
            if (!imm_in_range(imm, -32'sd4096, 32'sd4094)) code = ERR_RANGE;
            else if (imm[0])                               code = ERR_ALIGN;
            else                                           code = ERR_NONE;
         end
         FMT_J: begin
            if (!imm_in_range(imm, -32'sd1048576, 32'sd1048574)) code = ERR_RANGE;
            else if (imm[0])                                     code = ERR_ALIGN;
            else                                                 code = ERR_NONE;
         end
         FMT_U: begin
            if (imm[11:0] != 12'd0) code = ERR_ALIGN;
            else                    code = ERR_NONE;
         end
         default: code = ERR_FMT;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/imm_scatter.sv
// Places immediate bits into their RV32I instruction positions for a given
// format; every non-immediate bit position is left zero.
module imm_scatter
   import rv_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [31:0] imm,
   output logic [31:0] bits
);

   // Immediate bit placement per format
   always_comb begin
      bits = 32'd0;
      case (fmt)
         FMT_I:   bits = {imm[11:0], 20'd0};
         FMT_S:   bits = {imm[11:5], 13'd0, imm[4:0], 7'd0};
         FMT_B:   bits = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
         FMT_U:   bits = {imm[31:12], 12'd0};
         FMT_J:   bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
         default: bits = 32'd0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage elastic RV32I instruction encoder: stage 1 captures fields and checks
// the immediate, stage 2 holds the packed word, with saturating ok/error counters.
module instr_encoder #(
   parameter int          CNT_W    = 16,
   parameter logic [31:0] NOP_WORD = rv_pkg::NOP_WORD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_fmt,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [1:0]       out_err_code,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt_ok,
   output logic [CNT_W-1:0] cnt_err
);
   import rv_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic        s1_valid_r;
   logic [2:0]  s1_fmt_r;
   logic [6:0]  s1_opcode_r;
   logic [4:0]  s1_rd_r, s1_rs1_r, s1_rs2_r;
   logic [2:0]  s1_funct3_r;
   logic [6:0]  s1_funct7_r;
   logic [31:0] s1_imm_r;
   logic [1:0]  s1_err_r;

   logic        out_valid_r, out_err_r;
   logic [31:0] out_instr_r;
   logic [1:0]  out_err_code_r;
   logic [CNT_W-1:0] cnt_ok_r, cnt_err_r;

   logic        s1_ready_s, s2_ready_s, out_xfer_s;
   logic [31:0] reg_bits_s, imm_bits_s, packed_s;

   assign s2_ready_s = !out_valid_r || out_ready;
   assign s1_ready_s = !s1_valid_r || s2_ready_s;
   assign out_xfer_s = out_valid_r && out_ready;

   // Stage 1: capture fields and classify the immediate
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r  <= 1'b0;
         s1_fmt_r    <= 3'd0;
         s1_opcode_r <= 7'd0;
         s1_rd_r     <= 5'd0;
         s1_rs1_r    <= 5'd0;
         s1_rs2_r    <= 5'd0;
         s1_funct3_r <= 3'd0;
         s1_funct7_r <= 7'd0;
         s1_imm_r    <= 32'd0;
         s1_err_r    <= ERR_NONE;
      end else if (s1_ready_s) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_fmt_r    <= in_fmt;
            s1_opcode_r <= in_opcode;
            s1_rd_r     <= in_rd;
            s1_rs1_r    <= in_rs1;
            s1_rs2_r    <= in_rs2;
            s1_funct3_r <= in_funct3;
            s1_funct7_r <= in_funct7;
            s1_imm_r    <= in_imm;
            s1_err_r    <= check_imm(in_fmt, in_imm);
         end
      end
   end

   // Register-index and opcode fields per format; immediates come from imm_scatter
   always_comb begin
      reg_bits_s = 32'd0;
      case (s1_fmt_r)
         FMT_R:        reg_bits_s = {s1_funct7_r, s1_rs2_r, s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
         FMT_I:        reg_bits_s = {12'd0, s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
         FMT_S, FMT_B: reg_bits_s = {7'd0, s1_rs2_r, s1_rs1_r, s1_funct3_r, 5'd0, s1_opcode_r};
         FMT_U, FMT_J: reg_bits_s = {20'd0, s1_rd_r, s1_opcode_r};
         default:      reg_bits_s = 32'd0;
      endcase
   end

   imm_scatter u_imm_scatter (
      .fmt  (s1_fmt_r),
      .imm  (s1_imm_r),
      .bits (imm_bits_s)
   );

   assign packed_s = reg_bits_s | imm_bits_s;

   // Stage 2: output register, held while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r    <= 1'b0;
         out_instr_r    <= 32'd0;
         out_err_r      <= 1'b0;
         out_err_code_r <= ERR_NONE;
      end else if (s2_ready_s) begin
         out_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            out_err_code_r <= s1_err_r;
            out_err_r      <= (s1_err_r != ERR_NONE);
            out_instr_r    <= (s1_err_r != ERR_NONE) ? NOP_WORD : packed_s;
         end
      end
   end

   // Saturating delivery counters; a clear wins over a same-cycle transfer
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cnt_ok_r  <= '0;
         cnt_err_r <= '0;
      end else if (out_xfer_s) begin
         if (out_err_r) begin
            if (cnt_err_r != CNT_MAX) cnt_err_r <= cnt_err_r + CNT_ONE;
         end else begin
            if (cnt_ok_r != CNT_MAX) cnt_ok_r <= cnt_ok_r + CNT_ONE;
         end
      end
   end

   assign in_ready     = s1_ready_s;
   assign out_valid    = out_valid_r;
   assign out_instr    = out_instr_r;
   assign out_err      = out_err_r;
   assign out_err_code = out_err_code_r;
   assign cnt_ok       = cnt_ok_r;
   assign cnt_err      = cnt_err_r;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs decoded instruction fields (format, opcode, register indices, funct fields, 32-bit immediate) into a 32-bit RV32I instruction word.
- It is the inverse of the core's immediate generator: immediate bits are scattered into their I/S/B/U/J positions, not gathered out of them.
- Used by the self-test instruction injector and by debug-mode instruction insertion ahead of the fetch mux.
- Two-stage elastic pipeline (check, then pack) with valid/ready handshake on both sides, range/alignment checking, and saturating statistics counters.

Parameters:
- CNT_W, 16, width of the ok/error statistics counters.
- NOP_WORD, 32'h00000013, word emitted in place of any instruction that fails checking.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept input this cycle.
- in_fmt  in  3  format: 0=R 1=I 2=S 3=B 4=U 5=J; 6 and 7 are illegal.
- in_opcode  in  7  opcode, placed verbatim in [6:0].
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R only).
- in_imm  in  32  signed byte-offset or value immediate.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  encoded instruction.
- out_err  out  1  word failed checking; out_instr is NOP_WORD.
- out_err_code  out  2  0=none 1=range 2=misaligned 3=illegal fmt.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_ok  out  CNT_W  count of error-free words delivered.
- cnt_err  out  CNT_W  count of error words delivered.

Behaviour:
- Reset: out_valid=0, out_instr=0, out_err=0, out_err_code=0, cnt_ok=0, cnt_err=0, both stage valid bits=0. in_ready=1 in the first cycle after reset. Reset aborts in-flight items with no output.
- Transfer occurs when valid and ready are both high on a rising edge.
- Latency is 2 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Stage 1 registers the fields and computes the error code. Stage 2 registers the packed word; its outputs drive out_* directly.
- Ready chain: s2_ready = !s2_valid || out_ready; s1_ready = !s1_valid || s2_ready; in_ready = s1_ready.
- Order is preserved and there is no loss or duplication.
- out_* stay stable while out_valid=1 and out_ready=0.
- Checks, evaluated in priority order illegal fmt > range > misaligned:
  - I/S: imm must lie in [-2048, 2047].
  - B: imm must lie in [-4096, 4094] and imm[0]=0.
  - J: imm must lie in [-1048576, 1048574] and imm[0]=0.
  - U: imm[11:0] must be 0, otherwise error code 2.
  - R: imm is ignored.
- Packing:
  - R: {f7, rs2, rs1, f3, rd, op}.
  - I: {imm[11:0], rs1, f3, rd, op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - Fields unused by a format are ignored.
- Counters:
  - Increment on output transfer only: cnt_ok if out_err=0, else cnt_err.
  - Both saturate at all-ones.
  - cnt_clr takes priority over an increment in the same cycle; a simultaneous transfer is not counted.

Decomposition:
- Shared package rv_pkg holds the format enum (FMT_R..FMT_J), error code constants (ERR_NONE/RANGE/ALIGN/FMT), opcode constants and NOP_WORD.
- One natural sub-module, imm_scatter: combinational format-plus-immediate to instruction-bit placement, instantiated in stage 2.
- Handshake, checking and counters stay in the top module.

Test Plan:
- I fmt, op=0x13, rd=1, rs1=0, f3=0, imm=5 -> out_instr=0x00500093, err=0, out_valid exactly 2 cycles after transfer, cnt_ok=1.
- B fmt, op=0x63, rs1=rs2=0, f3=0, imm=-4 -> 0xFE000EE3. J fmt, op=0x6F, rd=1, imm=2048 -> 0x001000EF. U fmt, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
- S imm=2048 -> err=1, code=1, out_instr=0x00000013. B imm=3 -> code=2. fmt=6 -> code=3. cnt_err=3.
- Stream 4 back-to-back items with out_ready=0 for 4 cycles:
  - in_ready drops after 2 accepted.
  - out_* stay stable while stalled.
  - After release, all 4 emerge in order, one per cycle.
- Assert rst with both stages full -> next cycle out_valid=0, counters=0, in_ready=1; nothing is emitted afterwards.
- Hold cnt_clr during an output transfer -> counters read 0. Preload cnt_ok to 0xFFFF -> it stays 0xFFFF after another ok transfer.
